// File: rtl/load_scoreboard_pkg.sv
// Shared core widths used by the load scoreboard and the decode stage.
// Register-file geometry lives here so every pipeline stage agrees on it.
package load_scoreboard_pkg;
  localparam int REG_NUM = 32;
  localparam int REG_AW  = 5;
endpackage

// File: rtl/load_scoreboard.sv
// Pending-register scoreboard for long-latency producers, with RAW/WAW/capacity
// stall generation for decode and a sticky protocol-error flag.
module load_scoreboard
  import load_scoreboard_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              id_rs1_read,
  input  logic              id_rs2_read,
  input  logic [REG_AW-1:0] id_rs1_addr,
  input  logic [REG_AW-1:0] id_rs2_addr,
  input  logic              id_rd_write,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic              id_long_lat,
  input  logic              id_issue,
  input  logic              ret_valid,
  input  logic [REG_AW-1:0] ret_rd_addr,
  input  logic              kill_valid,
  input  logic [REG_AW-1:0] kill_rd_addr,
  output logic              sb_stall,
  output logic              sb_full,
  output logic [REG_NUM-1:0] sb_pending,
  output logic              sb_err
);

  localparam int SB_CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [SB_CNT_W-1:0] CNT_MAX  = SB_CNT_W'(MAX_OUTSTANDING);
  localparam logic [SB_CNT_W:0]   CNT_MAXW = (SB_CNT_W + 1)'(MAX_OUTSTANDING);

  logic [REG_NUM-1:0]  r_pending;
  logic [SB_CNT_W-1:0] r_count;
  logic                r_err;

  logic                w_set, w_ret, w_kill;
  logic                w_raw1, w_raw2, w_waw, w_cap, w_stall, w_err_now;
  logic [REG_NUM-1:0]  w_pending_next;
  logic [SB_CNT_W:0]   w_cnt_up, w_cnt_dn, w_cnt_diff;
  logic [SB_CNT_W-1:0] w_count_next;

  assign w_set  = id_issue & id_long_lat & id_rd_write & (id_rd_addr != '0);
  assign w_ret  = ret_valid & (ret_rd_addr != '0);
  assign w_kill = kill_valid & (kill_rd_addr != '0);

  // A register whose data returns this cycle is forwarded from WB, so it never stalls.
  assign w_raw1 = id_rs1_read & (id_rs1_addr != '0) & r_pending[id_rs1_addr] &
                  ~(w_ret & (ret_rd_addr == id_rs1_addr));
  assign w_raw2 = id_rs2_read & (id_rs2_addr != '0) & r_pending[id_rs2_addr] &
                  ~(w_ret & (ret_rd_addr == id_rs2_addr));
  assign w_waw  = id_rd_write & (id_rd_addr != '0) & r_pending[id_rd_addr] &
                  ~(w_ret & (ret_rd_addr == id_rd_addr));
  assign w_cap  = id_long_lat & id_rd_write & (id_rd_addr != '0) &
                  (r_count == CNT_MAX) & ~w_ret & ~w_kill;
  assign w_stall = id_valid & (w_raw1 | w_raw2 | w_waw | w_cap);

  assign w_err_now = (w_ret & ~r_pending[ret_rd_addr]) |
                     (w_kill & ~r_pending[kill_rd_addr]) |
                     (w_ret & w_kill & (ret_rd_addr == kill_rd_addr)) |
                     (id_issue & w_stall);

  // Set beats clear on the same register: the newly issued producer owns it.
  assign w_pending_next[0] = 1'b0;
  genvar gi;
  for (gi = 1; gi < REG_NUM; gi++) begin : g_pend
    localparam logic [REG_AW-1:0] ADDR = REG_AW'(gi);
    assign w_pending_next[gi] =
      (w_set && (id_rd_addr == ADDR)) ? 1'b1 :
      ((w_ret && (ret_rd_addr == ADDR)) || (w_kill && (kill_rd_addr == ADDR))) ? 1'b0 :
      r_pending[gi];
  end

  // Saturate the count in both directions so protocol errors cannot wrap it.
  assign w_cnt_up   = {1'b0, r_count} + (SB_CNT_W + 1)'(w_set);
  assign w_cnt_dn   = (SB_CNT_W + 1)'(w_ret) + (SB_CNT_W + 1)'(w_kill);
  assign w_cnt_diff = w_cnt_up - w_cnt_dn;
  assign w_count_next = (w_cnt_up <= w_cnt_dn)   ? '0 :
                        (w_cnt_diff > CNT_MAXW)  ? CNT_MAX :
                        w_cnt_diff[SB_CNT_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
      r_count   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_pending <= w_pending_next;
      r_count   <= w_count_next;
      if (w_err_now) r_err <= 1'b1;
    end
  end

  assign sb_stall   = w_stall;
  assign sb_full    = (r_count == CNT_MAX);
  assign sb_pending = r_pending;
  assign sb_err     = r_err;

endmodule

// File: tb/tb_load_scoreboard.sv
// Randomized and directed bench for load_scoreboard against a set/count model.
// A negedge compare process checks every output each cycle.
module tb_load_scoreboard;
  localparam int MAX = 2;

  logic        clk, rst;
  logic        id_valid, id_rs1_read, id_rs2_read, id_rd_write, id_long_lat, id_issue;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic        ret_valid, kill_valid;
  logic [4:0]  ret_rd_addr, kill_rd_addr;
  logic        sb_stall, sb_full, sb_err;
  logic [31:0] sb_pending;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 0;

  // Reference model: set of waiting registers, number in flight, sticky error.
  logic [31:0] mpend = '0;
  int          mcount = 0;
  logic        merr = 0;

  load_scoreboard #(.MAX_OUTSTANDING(MAX)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1_read(id_rs1_read), .id_rs2_read(id_rs2_read),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rd_write(id_rd_write), .id_rd_addr(id_rd_addr),
    .id_long_lat(id_long_lat), .id_issue(id_issue),
    .ret_valid(ret_valid), .ret_rd_addr(ret_rd_addr),
    .kill_valid(kill_valid), .kill_rd_addr(kill_rd_addr),
    .sb_stall(sb_stall), .sb_full(sb_full), .sb_pending(sb_pending), .sb_err(sb_err)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic bit waits_on(input logic rd, input logic [4:0] a);
    return rd && (a != 0) && mpend[a] && !(ret_valid && ret_rd_addr == a);
  endfunction

  function automatic bit exp_stall();
    bit s;
    s = 0;
    if (!id_valid) return 0;
    if (waits_on(id_rs1_read, id_rs1_addr)) s = 1;
    if (waits_on(id_rs2_read, id_rs2_addr)) s = 1;
    if (waits_on(id_rd_write, id_rd_addr)) s = 1;
    if (id_long_lat && id_rd_write && id_rd_addr != 0 && mcount == MAX &&
        !(ret_valid && ret_rd_addr != 0) && !(kill_valid && kill_rd_addr != 0)) s = 1;
    return s;
  endfunction

  always @(posedge clk) begin : model_upd
    logic [31:0] np;
    int          c;
    logic        e, s, r, k;
    np = mpend; c = mcount; e = merr;
    if (rst) begin
      np = '0; c = 0; e = 0;
    end else begin
      s = id_issue && id_long_lat && id_rd_write && id_rd_addr != 0;
      r = ret_valid && ret_rd_addr != 0;
      k = kill_valid && kill_rd_addr != 0;
      if ((r && !mpend[ret_rd_addr]) || (k && !mpend[kill_rd_addr]) ||
          (r && k && ret_rd_addr == kill_rd_addr) || (id_issue && exp_stall())) e = 1;
      if (r) np[ret_rd_addr] = 0;
      if (k) np[kill_rd_addr] = 0;
      if (s) np[id_rd_addr] = 1;
      c = mcount + int'(s) - int'(r) - int'(k);
      if (c < 0) c = 0;
      if (c > MAX) c = MAX;
    end
    mpend  <= np;
    mcount <= c;
    merr   <= e;
    cyc    <= cyc + 1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks += 4;
      if (sb_stall !== exp_stall()) begin
        errors++; $display("FAIL stall cyc=%0d got=%b exp=%b", cyc, sb_stall, exp_stall());
      end
      if (sb_full !== (mcount == MAX)) begin
        errors++; $display("FAIL full cyc=%0d got=%b exp=%b", cyc, sb_full, mcount == MAX);
      end
      if (sb_pending !== mpend) begin
        errors++; $display("FAIL pending cyc=%0d got=%h exp=%h", cyc, sb_pending, mpend);
      end
      if (sb_err !== merr) begin
        errors++; $display("FAIL err cyc=%0d got=%b exp=%b", cyc, sb_err, merr);
      end
    end
  end

  task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  task automatic idle();
    id_valid = 0; id_rs1_read = 0; id_rs2_read = 0; id_rd_write = 0; id_long_lat = 0;
    id_issue = 0; id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0;
    ret_valid = 0; ret_rd_addr = 0; kill_valid = 0; kill_rd_addr = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    idle();
  endtask

  task automatic load(input logic [4:0] rd, input logic issue);
    id_valid = 1; id_rd_write = 1; id_long_lat = 1; id_rd_addr = rd; id_issue = issue;
  endtask

  task automatic add_dep(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    id_valid = 1; id_rs1_read = 1; id_rs2_read = 1; id_rd_write = 1;
    id_rs1_addr = rs1; id_rs2_addr = rs2; id_rd_addr = rd;
  endtask

  task automatic ret(input logic [4:0] a);
    ret_valid = 1; ret_rd_addr = a;
  endtask

  initial begin
    int q[$];
    idle();
    rst = 1;
    @(posedge clk); #1;
    chk_en = 1;
    add_dep(5, 5, 6);
    @(negedge clk);
    lit("rst_pending", sb_pending, 0);
    lit("rst_stall", {31'b0, sb_stall}, 0);
    tick();
    rst = 0;

    // Load x5 issued, dependent stalls until the return cycle.
    load(5, 1);
    @(negedge clk); lit("ld5_issue_stall", {31'b0, sb_stall}, 0);
    tick();
    add_dep(5, 1, 6);
    @(negedge clk); lit("raw_stall_c1", {31'b0, sb_stall}, 1); lit("pend5", sb_pending, 32'h20);
    tick();
    add_dep(5, 1, 6);
    @(negedge clk); lit("raw_stall_c2", {31'b0, sb_stall}, 1);
    tick();
    add_dep(5, 1, 6); ret(5); id_issue = 1;
    @(negedge clk); lit("raw_release", {31'b0, sb_stall}, 0); lit("pend5_c3", sb_pending, 32'h20);
    tick();
    @(negedge clk); lit("pend5_clear", sb_pending, 0);

    // Capacity cap with a same-cycle return freeing a slot.
    load(1, 1); tick();
    load(2, 1); tick();
    load(3, 0);
    @(negedge clk); lit("cap_stall", {31'b0, sb_stall}, 1); lit("cap_full", {31'b0, sb_full}, 1);
    tick();
    load(3, 1); ret(1);
    @(negedge clk); lit("cap_release", {31'b0, sb_stall}, 0);
    tick();
    @(negedge clk); lit("cap_full_after", {31'b0, sb_full}, 1); lit("cap_pend", sb_pending, 32'hC);
    ret(2); tick();
    ret(3); tick();

    // Squash of an issued load.
    load(7, 1); tick();
    kill_valid = 1; kill_rd_addr = 7; tick();
    add_dep(7, 0, 8);
    @(negedge clk); lit("kill_pend", sb_pending, 0); lit("kill_nostall", {31'b0, sb_stall}, 0);
    tick();

    // WAW on x9, then return and re-issue in one cycle.
    load(9, 1); tick();
    load(9, 0);
    @(negedge clk); lit("waw_stall", {31'b0, sb_stall}, 1);
    tick();
    load(9, 1); ret(9);
    @(negedge clk); lit("waw_release", {31'b0, sb_stall}, 0);
    tick();
    @(negedge clk); lit("waw_pend", sb_pending, 32'h200); lit("waw_notfull", {31'b0, sb_full}, 0);
    ret(9); tick();

    // x0 is never tracked.
    load(0, 1); id_rs1_read = 1; id_rs1_addr = 0;
    @(negedge clk); lit("x0_nostall", {31'b0, sb_stall}, 0);
    tick();
    @(negedge clk); lit("x0_pend", sb_pending, 0);

    // Spurious return sets sticky error; reset clears everything.
    load(13, 1); tick();
    ret(4); tick();
    @(negedge clk); lit("err_set", {31'b0, sb_err}, 1);
    tick();
    @(negedge clk); lit("err_sticky", {31'b0, sb_err}, 1);
    rst = 1; tick();
    @(negedge clk); lit("rst_err", {31'b0, sb_err}, 0); lit("rst_pend", sb_pending, 0);
    lit("rst_full", {31'b0, sb_full}, 0);
    rst = 0; tick();

    // Randomized traffic, mostly protocol-clean with rare violations and resets.
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      id_valid    = $urandom_range(0, 3) != 0;
      id_rs1_read = $urandom_range(0, 1) == 1;
      id_rs2_read = $urandom_range(0, 1) == 1;
      id_rd_write = $urandom_range(0, 3) != 0;
      id_long_lat = $urandom_range(0, 1) == 1;
      id_rs1_addr = 5'($urandom_range(0, 12));
      id_rs2_addr = 5'($urandom_range(0, 12));
      id_rd_addr  = 5'($urandom_range(0, 12));
      q.delete();
      for (int i = 1; i < 32; i++) if (mpend[i]) q.push_back(i);
      if (q.size() > 0 && $urandom_range(0, 9) < 4) begin
        ret_valid = 1; ret_rd_addr = 5'(q[$urandom_range(0, q.size() - 1)]);
      end
      if (q.size() > 0 && $urandom_range(0, 9) == 0) begin
        kill_valid = 1; kill_rd_addr = 5'(q[$urandom_range(0, q.size() - 1)]);
        if (ret_valid && kill_rd_addr == ret_rd_addr && $urandom_range(0, 3) != 0) kill_valid = 0;
      end
      if ($urandom_range(0, 199) == 0) begin
        ret_valid = 1; ret_rd_addr = 5'($urandom_range(1, 31));
      end
      id_issue = id_valid && (!exp_stall() || $urandom_range(0, 199) == 0) &&
                 $urandom_range(0, 3) != 0;
      @(negedge clk);
      tick();
    end
    rst = 0;
    @(negedge clk);
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/load_scoreboard.md
# load_scoreboard

Tracks architectural registers awaiting data from long-latency producers (loads; later multi-cycle units) and tells the decode stage when it must hold an instruction. It sits beside the decode stage. It replaces per-stage load-hazard comparisons with one pending-bit vector that is set at issue and cleared at data return or squash. It also enforces a global cap on outstanding long-latency writes.

## Interface
- `REG_NUM`, 32: number of architectural registers; x0 is never tracked.
- `REG_AW`, 5: register address width, equal to clog2(REG_NUM).
- `MAX_OUTSTANDING`, 2: maximum number of long-latency writes in flight (≥1).
- `clk`  in  1: clock; all state updates on rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `id_valid`  in  1: decode holds a valid instruction.
- `id_rs1_read`, `id_rs2_read`  in  1: the instruction reads rs1 / rs2.
- `id_rs1_addr`, `id_rs2_addr`  in  REG_AW: source register addresses.
- `id_rd_write`  in  1: the instruction writes rd.
- `id_rd_addr`  in  REG_AW: destination register address.
- `id_long_lat`  in  1: the instruction is a long-latency producer (load).
- `id_issue`  in  1: decode→EX handshake completes this cycle (valid & ready & ~stall).
- `ret_valid`  in  1: long-latency data returns (load data at MEM/WB) this cycle.
- `ret_rd_addr`  in  REG_AW: register whose data returns.
- `kill_valid`  in  1: an issued long-latency instruction was squashed before memory access.
- `kill_rd_addr`  in  REG_AW: rd of the squashed instruction.
- `sb_stall`  out  1: decode must not issue this cycle.
- `sb_full`  out  1: outstanding count has reached MAX_OUTSTANDING.
- `sb_pending`  out  REG_NUM: current pending vector, exported for debug and the bench.
- `sb_err`  out  1: sticky protocol error.

## Operation
- State:
  - `pending[REG_NUM-1:0]`; bit 0 is tied to 0.
  - `count`, 0..MAX_OUTSTANDING.
  - `err`, sticky.
- Set rule: when `id_issue & id_long_lat & id_rd_write & id_rd_addr!=0`, set `pending[rd]` and increment `count`.
- Clear on return: when `ret_valid` and `ret_rd_addr!=0`, clear that bit and decrement `count`.
- Clear on squash: `kill_valid` clears `pending[kill_rd_addr]` and decrements `count`.
- Net update: set, return and kill may all occur in one cycle; `count` changes by +set −ret −kill.
- Same-register collisions:
  - If set and clear target the same register in one cycle, set wins (the new producer).
  - If return and kill target the same register in one cycle, `err` is set.
- RAW stall: `sb_stall` asserts when `id_valid` and a read source (rsN_read, addr≠0) has its pending bit set. No stall if that register's data returns this cycle (`ret_valid & ret_rd_addr==src`), because the WB forward supplies it.
- WAW stall: `sb_stall` asserts when `id_valid & id_rd_write & id_rd_addr!=0` and `pending[id_rd_addr]` is set and not returning this cycle.
- Capacity stall: `sb_stall` asserts when `id_valid & id_long_lat & id_rd_write & id_rd_addr!=0` and `count==MAX_OUTSTANDING` with no return or kill this cycle.
- Errors (`err` set, held until reset):
  - return or kill of a register whose bit is clear;
  - return and kill on the same register in one cycle;
  - `id_issue` asserted while `sb_stall` is high.
- On an error the state update still applies, with saturating `count` (never wraps below 0 or above MAX_OUTSTANDING).

## Timing
- `sb_stall` and `sb_full` are combinational from inputs and registered state; there is no added latency.
- Pending and count updates are visible the cycle after issue, return or kill.
- Issue-to-stall: an instruction issued in cycle N that sets bit r stalls a dependent decode from cycle N+1.
- Return in cycle M releases the dependent in cycle M itself.
- Reset: while `rst`=1, in the cycle after its edge, `pending`=0, `count`=0, `err`=0.
- Resulting output values in reset: `sb_pending`=0, `sb_full`=0, `sb_err`=0. `sb_stall` is 0 for any input, since no bit is pending and the count is below the cap.
- Reset mid-operation discards all pending state. Returns arriving after reset are flagged in `err`, so the pipeline must be reset together with the scoreboard.

## Structure
- `REG_NUM` and `REG_AW` come from the shared core header alongside the existing pipeline widths. A `SB_CNT_W` localparam, clog2(MAX_OUTSTANDING+1), is derived locally.
- No sub-module: the pending vector, counter and stall compare are small enough to live in one module.
- The decode stage drives `id_issue` from its own handshake and ORs `sb_stall` into its done term.

## Test plan
- Load x5 issued (cycle 0); `add x6,x5,x1` in decode from cycle 1 → `sb_stall`=1 until `ret_valid`, ret_rd=5, arrives in cycle 3. Stall drops in cycle 3, and `pending[5]`=0 in cycle 4.
- MAX_OUTSTANDING=2: loads to x1 and x2 issued, third load to x3 presented → `sb_stall`=1 and `sb_full`=1. Return of x1 in the same cycle → stall=0, issue accepted, `count` remains 2.
- Load x7 issued, then `kill_valid` with kill_rd=7 → `pending[7]`=0 and `count`=0 next cycle; a dependent on x7 proceeds without stall.
- WAW: load x9 pending, second load to x9 presented → stall. Return x9 and issue of the new load in the same cycle → `pending[9]` remains 1 and `count` is unchanged.
- x0 handling: load to x0 issued, and an instruction reading x0 → no pending bit set, no stall, `count`=0.
- Error and reset: `ret_valid` with ret_rd=4 while `pending[4]`=0 → `sb_err`=1 and sticky. Assert `rst` → `sb_err`, `sb_pending` and `count` are all 0 the following cycle.
